// File: rtl/dart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dart_pkg                                                     |
// | Description : Shared types and constants for the two-player dart game     |
// |               sequencer: FSM state encoding, winner codes, default point   |
// |               width and starting score, and a player-to-winner helper.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dart_pkg;

  // Game sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_WAIT_DART = 3'd2,
    ST_LOOKUP    = 3'd3,
    ST_APPLY     = 3'd4,
    ST_TURN_END  = 3'd5,
    ST_RESULT    = 3'd6,
    ST_FINISH    = 3'd7
  } dart_state_e;

  // winner_o encodings.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Default configuration.
  localparam int DART_PW          = 9;
  localparam int DART_START_POINT = 501;

  // Map the active-player bit (0 = player 1, 1 = player 2) to a winner code.
  function automatic logic [1:0] win_of_player(input logic player);
    return player ? WIN_P2 : WIN_P1;
  endfunction

endpackage : dart_pkg
`default_nettype wire

// File: rtl/dart_score_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dart_score_bank                                              |
// | Description : Holds both players' remaining points and the turn-start      |
// |               snapshot of the active player. Provides load / subtract /    |
// |               restore / zero controls on the active player's register and  |
// |               the compare flags the sequencer needs for the bust rule.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock                                                    |
// |   reset      in   asynchronous active-low reset                            |
// |   load_i     in   load both players with START_POINT                       |
// |   snap_i     in   copy active player's points into the turn snapshot       |
// |   sub_i      in   active points -= point_i                                 |
// |   restore_i  in   active points  = turn snapshot                           |
// |   zero_i     in   active points  = 0                                       |
// |   player_i   in   active player (0 = player 1, 1 = player 2)               |
// |   point_i    in   PW   latched dart value                                  |
// |   p1_o/p2_o  out  PW   remaining points of player 1 / player 2             |
// |   gt_o       out  point_i >  active points (bust)                          |
// |   eq_o       out  point_i == active points (exact finish)                  |
// +----------------------------------------------------------------------------+
module dart_score_bank
  import dart_pkg::*;
#(
  parameter int PW          = DART_PW,
  parameter int START_POINT = DART_START_POINT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          snap_i,
  input  logic          sub_i,
  input  logic          restore_i,
  input  logic          zero_i,
  input  logic          player_i,
  input  logic [PW-1:0] point_i,
  output logic [PW-1:0] p1_o,
  output logic [PW-1:0] p2_o,
  output logic          gt_o,
  output logic          eq_o
);

  localparam logic [PW-1:0] START_VAL = PW'(START_POINT);

  logic [PW-1:0] p1_q, p1_d;
  logic [PW-1:0] p2_q, p2_d;
  logic [PW-1:0] ts_q, ts_d;
  logic [PW-1:0] cur;
  logic [PW-1:0] cur_next;

  assign cur  = player_i ? p2_q : p1_q;
  assign gt_o = (point_i >  cur);
  assign eq_o = (point_i == cur);

  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    ts_d     = ts_q;
    cur_next = cur;

    if (load_i) begin
      p1_d = START_VAL;
      p2_d = START_VAL;
    end else begin
      // The sequencer only issues sub_i when point_i <= cur, so no wrap.
      if (sub_i)          cur_next = cur - point_i;
      else if (restore_i) cur_next = ts_q;
      else if (zero_i)    cur_next = '0;

      if (sub_i || restore_i || zero_i) begin
        if (player_i) p2_d = cur_next;
        else          p1_d = cur_next;
      end
    end

    if (snap_i) ts_d = cur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q <= '0;
      p2_q <= '0;
      ts_q <= '0;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
      ts_q <= ts_d;
    end
  end

  assign p1_o = p1_q;
  assign p2_o = p2_q;

endmodule : dart_score_bank
`default_nettype wire

// File: rtl/dart_turn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dart_turn_ctrl                                               |
// | Description : Two-player dart game sequencer. Accepts dart hits, resolves  |
// |               their point value through a req/ack lookup, applies the      |
// |               multi-dart turn and bust rules and reports turn, bust, game  |
// |               end and winner status.                                       |
// | Options     : ROUND_LIMIT_EN - end the game after MAX_ROUND full rounds;   |
// |               the player with fewer points wins, equal points is a tie.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk                  in   clock                                          |
// |   reset                in   asynchronous active-low reset                  |
// |   start_i              in   start a game (IDLE / FINISH only)              |
// |   dart_come_i          in   single-cycle dart-hit strobe                   |
// |   dart_position_x/y_i  in   4  hit coordinates, valid with dart_come_i     |
// |   lut_req_o            out  point lookup request                          |
// |   lut_x_o / lut_y_o    out  4  lookup coordinates, stable during request  |
// |   lut_ack_i            in   lookup done, lut_point_i valid                 |
// |   lut_point_i          in   PW  looked-up point value                      |
// |   active_player_o      out  0 = player 1, 1 = player 2                     |
// |   dart_cnt_o           out  2  darts thrown in the current turn           |
// |   player_1/2_point_o   out  PW  remaining points                          |
// |   turn_done_o          out  end-of-turn pulse                             |
// |   bust_o               out  bust pulse                                    |
// |   game_set_o           out  game-end pulse                                |
// |   winner_o             out  2  00 none, 01 P1, 10 P2, 11 tie              |
// +----------------------------------------------------------------------------+
module dart_turn_ctrl
  import dart_pkg::*;
#(
  parameter int PW             = DART_PW,
  parameter int START_POINT    = DART_START_POINT,
  parameter int DARTS_PER_TURN = 3,
  parameter int MAX_ROUND      = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          dart_come_i,
  input  logic [3:0]    dart_position_x_i,
  input  logic [3:0]    dart_position_y_i,
  output logic          lut_req_o,
  output logic [3:0]    lut_x_o,
  output logic [3:0]    lut_y_o,
  input  logic          lut_ack_i,
  input  logic [PW-1:0] lut_point_i,
  output logic          active_player_o,
  output logic [1:0]    dart_cnt_o,
  output logic [PW-1:0] player_1_point_o,
  output logic [PW-1:0] player_2_point_o,
  output logic          turn_done_o,
  output logic          bust_o,
  output logic          game_set_o,
  output logic [1:0]    winner_o
);

  localparam int         RW        = (MAX_ROUND > 1) ? $clog2(MAX_ROUND + 1) : 1;
  localparam logic [1:0] DART_LAST = 2'(DARTS_PER_TURN);

  dart_state_e   state_q, state_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [PW-1:0] pt_q, pt_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          player_q, player_d;
  logic [RW-1:0] round_q, round_d;
  logic [1:0]    winner_q, winner_d;
  logic          snap_pend_q, snap_pend_d;

  logic          bank_load, bank_snap, bank_sub, bank_restore, bank_zero;
  logic          pt_gt, pt_eq;
  logic [PW-1:0] p1_pts, p2_pts;
  logic [1:0]    cnt_inc;
  logic [RW-1:0] round_inc;

  assign cnt_inc   = cnt_q + 2'd1;
  assign round_inc = round_q + RW'(1);

  dart_score_bank #(
    .PW          (PW),
    .START_POINT (START_POINT)
  ) u_score_bank (
    .clk       (clk),
    .reset     (reset),
    .load_i    (bank_load),
    .snap_i    (bank_snap),
    .sub_i     (bank_sub),
    .restore_i (bank_restore),
    .zero_i    (bank_zero),
    .player_i  (player_q),
    .point_i   (pt_q),
    .p1_o      (p1_pts),
    .p2_o      (p2_pts),
    .gt_o      (pt_gt),
    .eq_o      (pt_eq)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pt_d         = pt_q;
    cnt_d        = cnt_q;
    player_d     = player_q;
    round_d      = round_q;
    winner_d     = winner_q;
    snap_pend_d  = snap_pend_q;
    bank_load    = 1'b0;
    bank_snap    = 1'b0;
    bank_sub     = 1'b0;
    bank_restore = 1'b0;
    bank_zero    = 1'b0;
    lut_req_o    = 1'b0;
    turn_done_o  = 1'b0;
    bust_o       = 1'b0;
    game_set_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_INIT;
      end

      ST_INIT: begin
        bank_load   = 1'b1;
        winner_d    = WIN_NONE;
        cnt_d       = 2'd0;
        round_d     = '0;
        player_d    = 1'b0;
        snap_pend_d = 1'b1;
        state_d     = ST_WAIT_DART;
      end

      ST_WAIT_DART: begin
        // First cycle of a turn: remember where the turn started so a bust
        // can roll back every dart of this turn.
        if (snap_pend_q) begin
          bank_snap   = 1'b1;
          snap_pend_d = 1'b0;
        end
        if (dart_come_i) begin
          x_d     = dart_position_x_i;
          y_d     = dart_position_y_i;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        lut_req_o = 1'b1;
        if (lut_ack_i) begin
          pt_d    = lut_point_i;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        if (pt_gt) begin
          bank_restore = 1'b1;
          bust_o       = 1'b1;
          state_d      = ST_TURN_END;
        end else if (pt_eq) begin
          bank_zero = 1'b1;
          winner_d  = win_of_player(player_q);
          state_d   = ST_RESULT;
        end else begin
          bank_sub = 1'b1;
          cnt_d    = cnt_inc;
          state_d  = (cnt_inc == DART_LAST) ? ST_TURN_END : ST_WAIT_DART;
        end
      end

      ST_TURN_END: begin
        turn_done_o = 1'b1;
        cnt_d       = 2'd0;
        player_d    = ~player_q;
        snap_pend_d = 1'b1;
        state_d     = ST_WAIT_DART;
        // A round completes when player 2 hands back to player 1.
        if (player_q) begin
          round_d = round_inc;
`ifdef ROUND_LIMIT_EN
          if (round_inc == RW'(MAX_ROUND)) begin
            state_d = ST_RESULT;
            if (p1_pts < p2_pts)      winner_d = WIN_P1;
            else if (p2_pts < p1_pts) winner_d = WIN_P2;
            else                      winner_d = WIN_TIE;
          end
`endif
        end
      end

      ST_RESULT: begin
        game_set_o = 1'b1;
        state_d    = ST_FINISH;
      end

      ST_FINISH: begin
        if (start_i) state_d = ST_INIT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      pt_q        <= '0;
      cnt_q       <= 2'd0;
      player_q    <= 1'b0;
      round_q     <= '0;
      winner_q    <= WIN_NONE;
      snap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      player_q    <= player_d;
      round_q     <= round_d;
      winner_q    <= winner_d;
      snap_pend_q <= snap_pend_d;
    end
  end

  assign lut_x_o          = x_q;
  assign lut_y_o          = y_q;
  assign active_player_o  = player_q;
  assign dart_cnt_o       = cnt_q;
  assign player_1_point_o = p1_pts;
  assign player_2_point_o = p2_pts;
  assign winner_o         = winner_q;

endmodule : dart_turn_ctrl
`default_nettype wire

// File: doc/dart_turn_ctrl.md
Name: dart_turn_ctrl

Overview:
Game sequencer for the two-player dart machine. It accepts dart hits, drives a point-lookup datapath over a req/ack handshake, and keeps both players' remaining points. It enforces multi-dart turns with a bust rule and reports turn-done, game-set and winner status to the pattern/display side.

Parameters:
PW, 9, width of every point value
START_POINT, 501, initial points per player (must fit in PW bits)
DARTS_PER_TURN, 3, darts per turn (1..3)
MAX_ROUND, 20, round limit; used only with ROUND_LIMIT_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start_i  in  1  start a game; honoured only in IDLE and FINISH
dart_come_i  in  1  single-cycle dart-hit strobe
dart_position_x_i  in  4  hit x coordinate, valid with dart_come_i
dart_position_y_i  in  4  hit y coordinate, valid with dart_come_i
lut_req_o  out  1  point lookup request
lut_x_o  out  4  lookup x, stable while lut_req_o=1
lut_y_o  out  4  lookup y, stable while lut_req_o=1
lut_ack_i  in  1  lookup done; lut_point_i valid in the same cycle
lut_point_i  in  PW  point value of the looked-up position
active_player_o  out  1  0 = player 1, 1 = player 2
dart_cnt_o  out  2  darts already thrown in the current turn
player_1_point_o  out  PW  player 1 remaining points
player_2_point_o  out  PW  player 2 remaining points
turn_done_o  out  1  1-cycle pulse at the end of each turn
bust_o  out  1  1-cycle pulse when a turn is busted
game_set_o  out  1  1-cycle pulse when the game ends
winner_o  out  2  00 none, 01 player 1, 10 player 2, 11 tie

Behaviour:
- Reset (async, active-low): state=IDLE. All outputs 0, including both point outputs, winner_o, round counter and turn snapshot.
- FSM states:
  - IDLE: on start_i go to INIT.
  - INIT: load both players with START_POINT; clear winner_o, dart_cnt, round; active player = player 1; go to WAIT_DART.
  - WAIT_DART: on dart_come_i, latch x/y and go to LOOKUP. The first cycle of WAIT_DART at the start of each turn snapshots the active player's points into turn_start.
  - LOOKUP: lut_req_o=1 with the latched x/y held. When lut_ack_i=1, latch lut_point_i and go to APPLY. No timeout; the ack may arrive in the same cycle as the request.
  - APPLY, with cur = active player's points and p = latched point:
    - p>cur: bust. Restore cur to turn_start, pulse bust_o, go to TURN_END.
    - p==cur: cur=0, winner_o = active player, go to RESULT.
    - otherwise: cur -= p, increment dart_cnt. If dart_cnt reaches DARTS_PER_TURN go to TURN_END, else go to WAIT_DART.
  - TURN_END: pulse turn_done_o, clear dart_cnt, toggle active player. Leaving player 2's turn increments round. Go to WAIT_DART.
  - RESULT: pulse game_set_o, go to FINISH.
  - FINISH: hold points and winner_o; on start_i go to INIT.
- Event handling:
  - dart_come_i outside WAIT_DART is dropped (no queuing).
  - lut_ack_i outside LOOKUP is ignored.
  - start_i outside IDLE/FINISH is ignored.
- Latency: dart_come_i to point update is 3 cycles with a same-cycle ack (WAIT_DART→LOOKUP→APPLY, update on the APPLY edge).
- Arithmetic: unsigned PW-bit. Subtraction happens only when p<=cur, so it never wraps.
- Reset mid-operation aborts immediately: lut_req_o drops asynchronously and no partial score is kept.

Optional Feature:
ROUND_LIMIT_EN:
- Defined: in TURN_END, if the incremented round equals MAX_ROUND, go to RESULT instead of WAIT_DART. winner_o = player with fewer points; 11 if the points are equal.
- Undefined: no round counter limit; the game ends only on an exact zero.

Decomposition:
- dart_pkg holds:
  - state enum
  - winner encodings (WIN_NONE/WIN_P1/WIN_P2/WIN_TIE)
  - default PW and START_POINT constants
- One natural sub-module, dart_score_bank. It contains the two point registers and the turn_start snapshot, with load/subtract/restore controls and the p>cur / p==cur compare flags. The FSM stays in dart_turn_ctrl.

Test Plan:
- Bench LUT returns 60 at (0,0) with a 1-cycle ack. start_i, then player 1 throws 3 darts → player_1_point_o=321, one turn_done_o pulse, active_player_o=1.
- START_POINT=100: player 1 throws 60 then 60 → bust_o pulse on the second dart, player_1_point_o=100, turn ends after 2 darts.
- START_POINT=120: player 1 throws 60 then 60 → point=0, game_set_o pulse, winner_o=01, FINISH. Further darts leave all outputs unchanged.
- Delay lut_ack_i by 5 cycles and pulse dart_come_i mid-stall with a new x/y → lut_x_o/lut_y_o stay stable, extra dart dropped, only one subtraction.
- Assert reset during LOOKUP → lut_req_o=0 and both points=0 immediately. start_i after release → both points=501.
- ROUND_LIMIT_EN, MAX_ROUND=1, each player throws 3×60 → game_set_o after player 2's turn, winner_o=11. Repeat with player 2 throwing 3×20 → winner_o=01.
